// File: rtl/mmcm_drp_responder_if.sv
// DRP bus between the register-side initiator (master) and the emulated MMCM port (slave).
interface mmcm_drp_responder_if #(
  parameter int pADDR_W = 7,
  parameter int pDATA_W = 16
) ();
  logic [pADDR_W-1:0] drp_addr;
  logic               drp_den;
  logic               drp_dwe;
  logic [pDATA_W-1:0] drp_din;
  logic [pDATA_W-1:0] drp_dout;
  logic               drp_drdy;

  modport master (
    output drp_addr, drp_den, drp_dwe, drp_din,
    input  drp_dout, drp_drdy
  );

  modport slave (
    input  drp_addr, drp_den, drp_dwe, drp_din,
    output drp_dout, drp_drdy
  );
endinterface

// File: rtl/mmcm_drp_responder.sv
// Behavioural MMCM DRP target: register file with fixed-latency handshake, lock emulation
// and sticky protocol-error flags for simulation builds without the MMCM primitive.
module mmcm_drp_responder #(
  parameter int pADDR_W      = 7,
  parameter int pDATA_W      = 16,
  parameter int pLATENCY     = 4,
  parameter int pLOCK_CYCLES = 100
) (
  input  logic                       clk_usb,
  input  logic                       reset_i,
  mmcm_drp_responder_if.slave        drp,
  input  logic                       mmcm_reset,
  output logic                       locked,
  input  logic                       err_clear,
  output logic [1:0]                 err,
  output logic [7:0]                 wr_count
);

  localparam int                 DEPTH    = 2 ** pADDR_W;
  localparam int                 LOCK_W   = $clog2(pLOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0]  LOCK_MAX = LOCK_W'(pLOCK_CYCLES);
  localparam logic [3:0]         LAT_LOAD = 4'(pLATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state_q;
  logic [3:0]         lat_q;
  logic [pADDR_W-1:0] addr_q;
  logic [pDATA_W-1:0] din_q;
  logic               dwe_q;
  logic [pDATA_W-1:0] dout_q;
  logic               drdy_q;
  logic               locked_q;
  logic [1:0]         err_q;
  logic [1:0]         err_d;
  logic [7:0]         wr_count_q;
  logic [LOCK_W-1:0]  lock_q;
  logic [LOCK_W-1:0]  lock_d;
  logic [pDATA_W-1:0] mem_q [DEPTH];

  logic               commit_wr;
  logic               overlap;

  // A committed write models a reconfiguration of a running MMCM: it drops lock.
  always_comb begin
    commit_wr = (state_q == ACK) && dwe_q;
    overlap   = drp.drp_den && (state_q != IDLE);
    err_d     = (err_q & ~{2{err_clear}}) | {commit_wr && !mmcm_reset, overlap};
    lock_d    = lock_q;
    if (mmcm_reset || commit_wr) begin
      lock_d = '0;
    end else if (lock_q != LOCK_MAX) begin
      lock_d = lock_q + 1'b1;
    end
  end

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      dwe_q      <= 1'b0;
      dout_q     <= '0;
      drdy_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= '0;
      wr_count_q <= '0;
      lock_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      drdy_q   <= 1'b0;
      err_q    <= err_d;
      lock_q   <= lock_d;
      locked_q <= (lock_d == LOCK_MAX);
      // drdy and read data are registered on entry to ACK so they appear together.
      case (state_q)
        IDLE: begin
          if (drp.drp_den) begin
            addr_q <= drp.drp_addr;
            din_q  <= drp.drp_din;
            dwe_q  <= drp.drp_dwe;
            lat_q  <= LAT_LOAD;
            if (pLATENCY == 1) begin
              state_q <= ACK;
              drdy_q  <= 1'b1;
              if (!drp.drp_dwe) begin
                dout_q <= mem_q[drp.drp_addr];
              end
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_q == 4'd1) begin
            state_q <= ACK;
            drdy_q  <= 1'b1;
            if (!dwe_q) begin
              dout_q <= mem_q[addr_q];
            end
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        ACK: begin
          if (dwe_q) begin
            mem_q[addr_q] <= din_q;
            wr_count_q    <= wr_count_q + 8'd1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drp.drp_dout = dout_q;
  assign drp.drp_drdy = drdy_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Bench for mmcm_drp_responder: transaction-level model of the latency-4 instance plus
// directed literal checks, and a second latency-1 instance for single-cycle behaviour.
module tb_mmcm_drp_responder;
  localparam int L = 4;
  localparam int P = 100;

  logic       clk_usb    = 1'b0;
  logic       reset_i    = 1'b1;
  logic       mmcm_reset = 1'b1;
  logic       err_clear  = 1'b0;
  logic       errB_clr   = 1'b0;
  logic       lockedA, lockedB;
  logic [1:0] errA, errB;
  logic [7:0] wrA, wrB;

  mmcm_drp_responder_if #(.pADDR_W(7), .pDATA_W(16)) drpA ();
  mmcm_drp_responder_if #(.pADDR_W(7), .pDATA_W(16)) drpB ();

  mmcm_drp_responder #(.pADDR_W(7), .pDATA_W(16), .pLATENCY(L), .pLOCK_CYCLES(P)) dutA (
    .clk_usb(clk_usb), .reset_i(reset_i), .drp(drpA.slave), .mmcm_reset(mmcm_reset),
    .locked(lockedA), .err_clear(err_clear), .err(errA), .wr_count(wrA)
  );

  mmcm_drp_responder #(.pADDR_W(7), .pDATA_W(16), .pLATENCY(1), .pLOCK_CYCLES(P)) dutB (
    .clk_usb(clk_usb), .reset_i(reset_i), .drp(drpB.slave), .mmcm_reset(mmcm_reset),
    .locked(lockedB), .err_clear(errB_clr), .err(errB), .wr_count(wrB)
  );

  always #5 clk_usb = ~clk_usb;

  int n_chk  = 0;
  int n_fail = 0;
  int cntA   = 0;
  int cntB   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of instance A: a request accepted at edge t0 completes
  // at edge t0+L; lock holds once P edges have passed since the last restart event.
  int          c = 0, t0 = 0, last = 0;
  bit          pend = 0, p_we = 0, ov, wc;
  logic [6:0]  p_a = '0;
  logic [15:0] p_d = '0;
  logic [15:0] mem [128];
  logic        m_drdy = 1'b0;
  logic [15:0] m_dout = '0;
  logic [1:0]  m_err  = '0;
  logic [7:0]  m_wr   = '0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    forever begin
      @(posedge clk_usb);
      c++;
      if (reset_i) begin
        pend   = 0;
        m_drdy = 1'b0;
        m_dout = '0;
        m_err  = '0;
        m_wr   = '0;
        last   = c;
        for (int i = 0; i < 128; i++) mem[i] = '0;
      end else begin
        ov = drpA.drp_den && pend;
        wc = 0;
        if (pend && c == t0 + L) begin
          if (p_we) begin
            mem[p_a] = p_d;
            m_wr     = m_wr + 8'd1;
            wc       = 1;
          end
          pend = 0;
        end
        if (drpA.drp_den && !ov) begin
          pend = 1;
          t0   = c;
          p_a  = drpA.drp_addr;
          p_we = drpA.drp_dwe;
          p_d  = drpA.drp_din;
        end
        m_drdy = pend && (c == t0 + L - 1);
        if (m_drdy && !p_we) m_dout = mem[p_a];
        m_err = (m_err & ~{2{err_clear}}) | {wc && !mmcm_reset, ov};
        if (mmcm_reset || wc) last = c;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_usb);
      if (!reset_i) begin
        chk("model_drdy",     32'(drpA.drp_drdy), 32'(m_drdy));
        chk("model_dout",     32'(drpA.drp_dout), 32'(m_dout));
        chk("model_err",      32'(errA),          32'(m_err));
        chk("model_wr_count", 32'(wrA),           32'(m_wr));
        chk("model_locked",   32'(lockedA),       32'((c - last) >= P));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_usb);
      if (drpA.drp_drdy) cntA++;
      if (drpB.drp_drdy) cntB++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_usb);
      #1;
    end
  endtask

  task automatic reqA(input logic [6:0] a, input logic we, input logic [15:0] d);
    @(negedge clk_usb);
    #1;
    drpA.drp_den  = 1'b1;
    drpA.drp_addr = a;
    drpA.drp_dwe  = we;
    drpA.drp_din  = d;
    @(negedge clk_usb);
    #1;
    drpA.drp_den  = 1'b0;
  endtask

  task automatic wait_drdyA(output int lat);
    lat = 1;
    while (!drpA.drp_drdy && lat < 20) begin
      @(negedge clk_usb);
      #1;
      lat++;
    end
  endtask

  task automatic reqB(input logic [6:0] a, input logic we, input logic [15:0] d);
    @(negedge clk_usb);
    #1;
    drpB.drp_den  = 1'b1;
    drpB.drp_addr = a;
    drpB.drp_dwe  = we;
    drpB.drp_din  = d;
    @(negedge clk_usb);
    #1;
    drpB.drp_den  = 1'b0;
  endtask

  int lat, n;

  initial begin
    drpA.drp_den = 1'b0; drpA.drp_addr = '0; drpA.drp_dwe = 1'b0; drpA.drp_din = '0;
    drpB.drp_den = 1'b0; drpB.drp_addr = '0; drpB.drp_dwe = 1'b0; drpB.drp_din = '0;
    step(3);
    reset_i = 1'b0;
    chk("reset_drdy",   32'(drpA.drp_drdy), 32'd0);
    chk("reset_dout",   32'(drpA.drp_dout), 32'd0);
    chk("reset_err",    32'(errA),          32'd0);
    chk("reset_wr",     32'(wrA),           32'd0);
    chk("reset_locked", 32'(lockedA),       32'd0);

    // T1: reset while a write is in WAIT aborts it
    reqA(7'h08, 1'b1, 16'hBEEF);
    step(1);
    reset_i = 1'b1;
    cntA = 0;
    step(3);
    reset_i = 1'b0;
    step(8);
    chk("t1_drdy_pulses", 32'(cntA),          32'd0);
    chk("t1_dout",        32'(drpA.drp_dout), 32'd0);
    chk("t1_err",         32'(errA),          32'd0);
    chk("t1_wr",          32'(wrA),           32'd0);
    chk("t1_locked",      32'(lockedA),       32'd0);

    // T2: write/read, latency 4
    reqA(7'h08, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t2_rd_latency",  32'(lat),           32'd4);
    chk("t2_aborted_wr",  32'(drpA.drp_dout), 32'h0000);
    reqA(7'h08, 1'b1, 16'h1041);
    wait_drdyA(lat);
    chk("t2_wr_latency",  32'(lat),           32'd4);
    step(1);
    chk("t2_wr_count",    32'(wrA),           32'd1);
    drpA.drp_addr = 7'h08; drpA.drp_dwe = 1'b1; drpA.drp_din = 16'hDEAD;
    step(2);
    drpA.drp_dwe = 1'b0;
    reqA(7'h08, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t2_rd_08",       32'(drpA.drp_dout), 32'h1041);
    reqA(7'h4F, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t2_rd_4f",       32'(drpA.drp_dout), 32'h0000);
    step(4);
    chk("t2_dout_hold",   32'(drpA.drp_dout), 32'h0000);

    // T3: overlapped request is dropped and flagged
    cntA = 0;
    @(negedge clk_usb); #1;
    drpA.drp_den = 1'b1; drpA.drp_addr = 7'h20; drpA.drp_dwe = 1'b1; drpA.drp_din = 16'hAAAA;
    step(1);
    drpA.drp_den = 1'b0;
    step(1);
    drpA.drp_den = 1'b1; drpA.drp_addr = 7'h21; drpA.drp_din = 16'h5555;
    step(1);
    drpA.drp_den = 1'b0;
    chk("t3_no_drdy_t2",  32'(drpA.drp_drdy), 32'd0);
    step(1);
    chk("t3_drdy_t4",     32'(drpA.drp_drdy), 32'd1);
    step(1);
    chk("t3_err",         32'(errA),          32'h1);
    chk("t3_wr",          32'(wrA),           32'd2);
    step(5);
    chk("t3_one_drdy",    32'(cntA),          32'd1);
    reqA(7'h21, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t3_dropped_rd",  32'(drpA.drp_dout), 32'h0000);
    reqA(7'h20, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t3_kept_rd",     32'(drpA.drp_dout), 32'hAAAA);
    step(1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    chk("t3_cleared",     32'(errA),          32'h0);
    step(2);
    drpA.drp_den = 1'b1; drpA.drp_addr = 7'h20; drpA.drp_dwe = 1'b0;
    step(1);
    drpA.drp_den = 1'b0;
    step(1);
    drpA.drp_den = 1'b1; err_clear = 1'b1;
    step(1);
    drpA.drp_den = 1'b0; err_clear = 1'b0;
    chk("t3_set_wins",    32'(errA),          32'h1);
    step(5);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;

    // T4: lock emulation
    mmcm_reset = 1'b0;
    n = 0;
    while (!lockedA && n < 300) begin
      step(1);
      n++;
    end
    chk("t4_lock_time",   32'(n),             32'd100);
    reqA(7'h08, 1'b0, 16'h0);
    wait_drdyA(lat);
    step(1);
    chk("t4_rd_locked",   32'(lockedA),       32'd1);
    chk("t4_rd_noerr",    32'(errA),          32'h0);
    reqA(7'h09, 1'b1, 16'h0123);
    wait_drdyA(lat);
    chk("t4_ack_locked",  32'(lockedA),       32'd1);
    step(1);
    chk("t4_unlocked",    32'(lockedA),       32'd0);
    chk("t4_err1",        32'(errA),          32'h2);
    chk("t4_wr",          32'(wrA),           32'd3);
    n = 0;
    while (!lockedA && n < 300) begin
      step(1);
      n++;
    end
    chk("t4_relock_time", 32'(n),             32'd100);
    mmcm_reset = 1'b1;
    err_clear  = 1'b1;
    step(1);
    err_clear  = 1'b0;

    // T5: 300 back-to-back writes from a clean reset
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
    step(1);
    cntA = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_usb); #1;
      drpA.drp_den  = 1'b1;
      drpA.drp_addr = 7'(i % 128);
      drpA.drp_dwe  = 1'b1;
      drpA.drp_din  = 16'(16'h1000 + i);
      @(negedge clk_usb); #1;
      drpA.drp_den  = 1'b0;
      repeat (3) @(negedge clk_usb);
    end
    step(8);
    chk("t5_wr_wrap",     32'(wrA),           32'd44);
    chk("t5_drdy_count",  32'(cntA),          32'd300);
    chk("t5_err",         32'(errA),          32'h0);
    reqA(7'd43, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t5_rd_43",       32'(drpA.drp_dout), 32'h112B);
    reqA(7'd0, 1'b0, 16'h0);
    wait_drdyA(lat);
    chk("t5_rd_0",        32'(drpA.drp_dout), 32'h1100);

    // T6: latency-1 instance
    cntB = 0;
    @(negedge clk_usb); #1;
    drpB.drp_den = 1'b1; drpB.drp_addr = 7'h05; drpB.drp_dwe = 1'b1; drpB.drp_din = 16'h00FF;
    step(1);
    drpB.drp_addr = 7'h06; drpB.drp_din = 16'h7777;
    chk("t6_drdy_t1",     32'(drpB.drp_drdy), 32'd1);
    step(1);
    drpB.drp_den = 1'b0;
    chk("t6_no_drdy",     32'(drpB.drp_drdy), 32'd0);
    chk("t6_err",         32'(errB),          32'h1);
    step(3);
    chk("t6_one_drdy",    32'(cntB),          32'd1);
    chk("t6_wr",          32'(wrB),           32'd1);
    reqB(7'h05, 1'b0, 16'h0);
    chk("t6_rd_05_drdy",  32'(drpB.drp_drdy), 32'd1);
    chk("t6_rd_05",       32'(drpB.drp_dout), 32'h00FF);
    step(1);
    reqB(7'h06, 1'b0, 16'h0);
    chk("t6_rd_06",       32'(drpB.drp_dout), 32'h0000);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
